// File: rtl/bsg_manycore_link_sif_absorber.sv
// Edge-of-array sink: absorbs forward packets, answers each with its embedded return packet,
// and swallows incoming return traffic while keeping simple statistics.
module bsg_manycore_link_sif_absorber #(
    parameter addr_width_p   = 32,
    parameter data_width_p   = 32,
    parameter x_cord_width_p = "inv",
    parameter y_cord_width_p = "inv",
    parameter fifo_els_p     = 2,
    parameter count_width_p  = 16,
    // An un-overridden "inv" collapses to 1 bit so the file still elaborates on its own.
    localparam x_w_lp = (x_cord_width_p >= 1 && x_cord_width_p <= 64) ? x_cord_width_p : 1,
    localparam y_w_lp = (y_cord_width_p >= 1 && y_cord_width_p <= 64) ? y_cord_width_p : 1,
    localparam return_packet_width_lp = 2 + data_width_p + 5 + y_w_lp + x_w_lp,
    localparam packet_width_lp = addr_width_p + 2 + data_width_p + return_packet_width_lp,
    localparam bsg_manycore_link_sif_width_lp = packet_width_lp + return_packet_width_lp + 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [bsg_manycore_link_sif_width_lp-1:0] link_sif_i,
    output logic [bsg_manycore_link_sif_width_lp-1:0] link_sif_o,
    input  logic                                      enable_i,
    input  logic                                      clear_i,
    output logic [count_width_p-1:0]                  fwd_count_o,
    output logic [count_width_p-1:0]                  rev_count_o,
    output logic                                      first_v_o,
    output logic [packet_width_lp-1:0]                first_data_o
);

    typedef struct packed {
        logic                       v;
        logic [packet_width_lp-1:0] data;
        logic                       ready_and_rev;
    } fwd_ch_s;

    typedef struct packed {
        logic                              v;
        logic [return_packet_width_lp-1:0] data;
        logic                              ready_and_rev;
    } rev_ch_s;

    typedef struct packed {
        fwd_ch_s fwd;
        rev_ch_s rev;
    } link_sif_s;

    localparam ptr_w_lp = $clog2(fifo_els_p);

    link_sif_s link_in, link_out;
    assign link_in    = link_sif_i;
    assign link_sif_o = link_out;

    logic [return_packet_width_lp-1:0] mem_q [fifo_els_p];
    logic [ptr_w_lp:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
    logic [count_width_p-1:0]          fwd_count_q, fwd_count_d, rev_count_q, rev_count_d;
    logic                              first_v_q, first_v_d;
    logic [packet_width_lp-1:0]        first_data_q, first_data_d;

    logic queue_empty, queue_full, fwd_rdy, accept, rev_v, deq;
    logic unused_link_bits;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign queue_empty = (wptr_q == rptr_q);
    assign queue_full  = (wptr_q[ptr_w_lp] != rptr_q[ptr_w_lp])
                      && (wptr_q[ptr_w_lp-1:0] == rptr_q[ptr_w_lp-1:0]);

    assign fwd_rdy = enable_i & ~queue_full & ~reset_i;
    assign accept  = link_in.fwd.v & fwd_rdy;
    assign rev_v   = ~queue_empty & ~reset_i;
    assign deq     = rev_v & link_in.rev.ready_and_rev;

    assign unused_link_bits = ^{link_in.fwd.ready_and_rev, link_in.rev.data};

    always_comb begin
        link_out                   = '0;
        link_out.fwd.ready_and_rev = fwd_rdy;
        link_out.rev.v             = rev_v;
        link_out.rev.data          = mem_q[rptr_q[ptr_w_lp-1:0]];
        link_out.rev.ready_and_rev = ~reset_i;
    end

    always_comb begin
        wptr_d       = wptr_q + {{ptr_w_lp{1'b0}}, accept};
        rptr_d       = rptr_q + {{ptr_w_lp{1'b0}}, deq};
        fwd_count_d  = fwd_count_q;
        rev_count_d  = rev_count_q;
        first_v_d    = first_v_q;
        first_data_d = first_data_q;
        // Clear wins over any same-cycle statistic update or capture.
        if (clear_i) begin
            fwd_count_d  = '0;
            rev_count_d  = '0;
            first_v_d    = 1'b0;
            first_data_d = '0;
        end else begin
            if (accept && !(&fwd_count_q))
                fwd_count_d = fwd_count_q + 1'b1;
            if (link_in.rev.v && !(&rev_count_q))
                rev_count_d = rev_count_q + 1'b1;
            if (accept && !first_v_q) begin
                first_v_d    = 1'b1;
                first_data_d = link_in.fwd.data;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            fwd_count_q  <= '0;
            rev_count_q  <= '0;
            first_v_q    <= 1'b0;
            first_data_q <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            fwd_count_q  <= fwd_count_d;
            rev_count_q  <= rev_count_d;
            first_v_q    <= first_v_d;
            first_data_q <= first_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept)
            mem_q[wptr_q[ptr_w_lp-1:0]] <= link_in.fwd.data[return_packet_width_lp-1:0];
    end

    assign fwd_count_o  = fwd_count_q;
    assign rev_count_o  = rev_count_q;
    assign first_v_o    = first_v_q;
    assign first_data_o = first_data_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && accept)
            $warning("link_sif_absorber: forward packet absorbed at the array edge");
        if (!reset_i && link_in.rev.v)
            $warning("link_sif_absorber: stray return packet discarded at the array edge");
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_link_sif_absorber.sv
// Directed bench for the link_sif absorber: vector table plus streaming and clear sequences.
module tb_bsg_manycore_link_sif_absorber;

    localparam int AW = 8, DW = 8, XW = 4, YW = 4, FE = 2, CW = 4;
    localparam int RW = 2 + DW + 5 + YW + XW;   // 23
    localparam int PW = AW + 2 + DW + RW;       // 41
    localparam int LW = PW + RW + 4;            // 68

    localparam logic H = 1'b1, L = 1'b0;
    localparam logic [RW-1:0] Z0 = '0;
    localparam logic [RW-1:0] R1 = 23'h012345, R2 = 23'h2ABCDE, R3 = 23'h055AA5,
                              R4 = 23'h7F00F1, R5 = 23'h111111, R6 = 23'h0C0DE0,
                              R7 = 23'h3FEED1, RVIN = 23'h07ABCD;

    logic          clk = 1'b0;
    logic          reset_i, enable_i, clear_i;
    logic [LW-1:0] link_sif_i, link_sif_o;
    logic [CW-1:0] fwd_count_o, rev_count_o;
    logic          first_v_o;
    logic [PW-1:0] first_data_o;

    logic          in_fwd_v, in_rev_v, in_rev_rdy;
    logic [PW-1:0] in_fwd_dat;

    always #5 clk = ~clk;

    assign link_sif_i = {in_fwd_v, in_fwd_dat, 1'b0, in_rev_v, RVIN, in_rev_rdy};

    wire          o_fwd_v   = link_sif_o[LW-1];
    wire [PW-1:0] o_fwd_dat = link_sif_o[LW-2 -: PW];
    wire          o_fwd_rdy = link_sif_o[RW+2];
    wire          o_rev_v   = link_sif_o[RW+1];
    wire [RW-1:0] o_rev_dat = link_sif_o[RW:1];
    wire          o_rev_rdy = link_sif_o[0];

    bsg_manycore_link_sif_absorber #(
        .addr_width_p(AW), .data_width_p(DW),
        .x_cord_width_p(XW), .y_cord_width_p(YW),
        .fifo_els_p(FE), .count_width_p(CW)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .link_sif_i(link_sif_i), .link_sif_o(link_sif_o),
        .enable_i(enable_i), .clear_i(clear_i),
        .fwd_count_o(fwd_count_o), .rev_count_o(rev_count_o),
        .first_v_o(first_v_o), .first_data_o(first_data_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_pkt(input logic [RW-1:0] ret);
        return {8'hA5, 2'b01, 8'h3C, ret};
    endfunction

    typedef struct {
        logic rst, en, clr, fv;
        logic [RW-1:0] fret;
        logic rrdy, rvin;
        logic e_frdy, e_rrdy, e_rv;
        logic [RW-1:0] e_rdat;
        logic [CW-1:0] e_fc, e_rc;
        logic e_first;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, en, clr, fv, input logic [RW-1:0] fret,
                       input logic rrdy, rvin, e_frdy, e_rrdy, e_rv,
                       input logic [RW-1:0] e_rdat, input logic [CW-1:0] e_fc, e_rc,
                       input logic e_first);
        vec_t v;
        v.rst = rst; v.en = en; v.clr = clr; v.fv = fv; v.fret = fret;
        v.rrdy = rrdy; v.rvin = rvin; v.e_frdy = e_frdy; v.e_rrdy = e_rrdy;
        v.e_rv = e_rv; v.e_rdat = e_rdat; v.e_fc = e_fc; v.e_rc = e_rc; v.e_first = e_first;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, en, clr, fv, input logic [RW-1:0] fret, input logic rrdy, rvin);
        reset_i = rst; enable_i = en; clear_i = clr;
        in_fwd_v = fv; in_fwd_dat = mk_pkt(fret);
        in_rev_rdy = rrdy; in_rev_v = rvin;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [RW-1:0] exp_q[$];
    int            n_rx;

    initial begin
        //   rst en clr fv fret rrdy rvin | frdy rrdy rv  rdat fc    rc    first
        add(H, H, L, L, Z0, H, L,   L, L, L, Z0, 4'd0, 4'd0, L);  // reset state
        add(L, H, L, H, R1, H, L,   H, H, L, Z0, 4'd0, 4'd0, L);  // single packet
        add(L, H, L, L, Z0, H, L,   H, H, H, R1, 4'd1, 4'd0, H);
        add(L, H, L, H, R2, L, L,   H, H, L, Z0, 4'd1, 4'd0, H);  // backpressure
        add(L, H, L, H, R3, L, L,   H, H, H, R2, 4'd2, 4'd0, H);
        add(L, H, L, H, R4, L, L,   L, H, H, R2, 4'd3, 4'd0, H);
        add(L, H, L, H, R4, H, L,   L, H, H, R2, 4'd3, 4'd0, H);
        add(L, H, L, H, R4, H, L,   H, H, H, R3, 4'd3, 4'd0, H);
        add(L, H, L, L, Z0, H, L,   H, H, H, R4, 4'd4, 4'd0, H);
        for (int i = 0; i < 5; i++)                                // return traffic
            add(L, H, L, L, Z0, H, H, H, H, L, Z0, 4'd4, CW'(i), H);
        add(L, H, L, L, Z0, H, L,   H, H, L, Z0, 4'd4, 4'd5, H);
        add(L, L, L, H, R5, H, L,   L, H, L, Z0, 4'd4, 4'd5, H);  // disabled
        add(L, L, L, H, R5, H, L,   L, H, L, Z0, 4'd4, 4'd5, H);
        add(L, H, H, H, R6, L, L,   H, H, L, Z0, 4'd4, 4'd5, H);  // clear + accept
        add(L, H, L, L, Z0, L, L,   H, H, H, R6, 4'd0, 4'd0, L);
        add(L, H, L, H, R7, L, L,   H, H, H, R6, 4'd0, 4'd0, L);
        add(H, H, L, H, R7, H, L,   L, L, L, Z0, 4'd1, 4'd0, H);  // reset, 2 queued
        add(L, H, L, L, Z0, H, L,   H, H, L, Z0, 4'd0, 4'd0, L);

        drive(H, H, L, L, Z0, H, L);
        next_cycle();

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].en, tbl[k].clr, tbl[k].fv, tbl[k].fret, tbl[k].rrdy, tbl[k].rvin);
            @(negedge clk);
            chk($sformatf("v%0d fwd_rdy", k), 64'(o_fwd_rdy), 64'(tbl[k].e_frdy));
            chk($sformatf("v%0d rev_rdy", k), 64'(o_rev_rdy), 64'(tbl[k].e_rrdy));
            chk($sformatf("v%0d rev_v", k), 64'(o_rev_v), 64'(tbl[k].e_rv));
            if (tbl[k].e_rv)
                chk($sformatf("v%0d rev_dat", k), 64'(o_rev_dat), 64'(tbl[k].e_rdat));
            chk($sformatf("v%0d fwd_cnt", k), 64'(fwd_count_o), 64'(tbl[k].e_fc));
            chk($sformatf("v%0d rev_cnt", k), 64'(rev_count_o), 64'(tbl[k].e_rc));
            chk($sformatf("v%0d first_v", k), 64'(first_v_o), 64'(tbl[k].e_first));
            chk($sformatf("v%0d fwd_out_idle", k), 64'({o_fwd_v, o_fwd_dat}), 64'(0));
            next_cycle();
        end
        chk("first_dat after reset", 64'(first_data_o), 64'(0));

        // 100-cycle stream with the return side always ready; saturates the 4-bit counter.
        n_rx = 0;
        for (int i = 0; i < 110; i++) begin
            if (i < 100) drive(L, H, L, H, RW'(i + 200), H, L);
            else         drive(L, H, L, L, Z0, H, L);
            @(negedge clk);
            if (i < 100) chk($sformatf("stream%0d fwd_rdy", i), 64'(o_fwd_rdy), 64'(1));
            if (o_rev_v && in_rev_rdy) begin
                if (exp_q.size() == 0) chk("stream extra rev", 64'(o_rev_dat), 64'(-1));
                else chk($sformatf("stream rx%0d", n_rx), 64'(o_rev_dat), 64'(exp_q.pop_front()));
                n_rx++;
            end
            if (o_fwd_rdy && in_fwd_v) exp_q.push_back(in_fwd_dat[RW-1:0]);
            next_cycle();
        end
        chk("stream rx count", 64'(n_rx), 64'(100));
        chk("stream leftover", 64'(exp_q.size()), 64'(0));
        chk("fwd_cnt saturated", 64'(fwd_count_o), 64'(15));
        chk("stream rev_cnt", 64'(rev_count_o), 64'(0));
        chk("first_v sticky", 64'(first_v_o), 64'(1));
        chk("first_dat capture", 64'(first_data_o), 64'(mk_pkt(RW'(200))));

        drive(L, H, H, L, Z0, H, H);
        next_cycle();
        drive(L, H, L, L, Z0, H, L);
        @(negedge clk);
        chk("clear fwd_cnt", 64'(fwd_count_o), 64'(0));
        chk("clear rev_cnt", 64'(rev_count_o), 64'(0));
        chk("clear first_v", 64'(first_v_o), 64'(0));
        chk("clear first_dat", 64'(first_data_o), 64'(0));

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
